// File: rtl/motion_pkg.sv
// Shared bridge-state encoding, mode codes and the mode/direction request decode
// for the H-bridge drive stage.
package motion_pkg;

   typedef enum logic [2:0] {
      S_OFF,
      S_DEAD,
      S_FWD,
      S_REV,
      S_BRAKE
   } bridge_state_t;

   localparam logic [1:0] MODE_COAST = 2'b00;
   localparam logic [1:0] MODE_DRIVE = 2'b01;
   localparam logic [1:0] MODE_BRAKE = 2'b10;

   // Mode 11 deliberately falls into coast together with 00.
   function automatic bridge_state_t request_of(input logic [1:0] mode, input logic dir_cmd);
      case (mode)
         MODE_DRIVE: return dir_cmd ? S_REV : S_FWD;
         MODE_BRAKE: return S_BRAKE;
         default:    return S_OFF;
      endcase
   endfunction

endpackage

// File: rtl/h_bridge_drive_if.sv
// Command and bridge-pin bundle between the PWM channel side and the H-bridge drive.
interface h_bridge_drive_if #(
   parameter int DT_WIDTH = 8
);
   logic                pwm_in;
   logic                dir_cmd;
   logic [1:0]          mode;
   logic [DT_WIDTH-1:0] dead_time;
   logic                bridge_in1;
   logic                bridge_in2;
   logic                dead_busy;
   logic                dir_active;

   modport master (
      output pwm_in, dir_cmd, mode, dead_time,
      input  bridge_in1, bridge_in2, dead_busy, dir_active
   );

   modport slave (
      input  pwm_in, dir_cmd, mode, dead_time,
      output bridge_in1, bridge_in2, dead_busy, dir_active
   );
endinterface

// File: rtl/dead_time_counter.sv
// Loadable down-counter for the bridge dead time; saturates at zero and flags it.
module dead_time_counter #(
   parameter int DT_WIDTH = 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                load,
   input  logic                dec,
   input  logic [DT_WIDTH-1:0] load_value,
   output logic                zero
);
   logic [DT_WIDTH-1:0] count_reg, count_next;

   always_comb begin
      count_next = count_reg;
      if (load) begin
         count_next = load_value;
      end else if (dec && (count_reg != '0)) begin
         count_next = count_reg - DT_WIDTH'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_reg <= '0;
      end else begin
         count_reg <= count_next;
      end
   end

   assign zero = (count_reg == '0);

endmodule

// File: rtl/h_bridge_drive.sv
// Turns PWM + direction/mode commands into H-bridge IN1/IN2, inserting a dead-time
// gap (both inputs low) on every change between drive polarities and brake.
module h_bridge_drive
   import motion_pkg::*;
#(
   parameter int DT_WIDTH = 8
) (
   input  logic            clk,
   input  logic            reset,
   h_bridge_drive_if.slave bus
);
   bridge_state_t state_reg, state_next;
   bridge_state_t target_reg, target_next;
   bridge_state_t request;

   logic cnt_load, cnt_dec, cnt_zero;
   logic in1_reg, in1_next;
   logic in2_reg, in2_next;
   logic busy_reg;
   logic dir_reg, dir_next;

   assign request = request_of(bus.mode, bus.dir_cmd);

   dead_time_counter #(
      .DT_WIDTH(DT_WIDTH)
   ) u_counter (
      .clk        (clk),
      .reset      (reset),
      .load       (cnt_load),
      .dec        (cnt_dec),
      .load_value (bus.dead_time),
      .zero       (cnt_zero)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg  <= S_OFF;
         target_reg <= S_OFF;
      end else begin
         state_reg  <= state_next;
         target_reg <= target_next;
      end
   end

   // Coasting is always safe, so an OFF request wins from any state without a gap.
   always_comb begin
      state_next  = state_reg;
      target_next = target_reg;
      cnt_load    = 1'b0;
      cnt_dec     = 1'b0;
      if (request == S_OFF) begin
         state_next = S_OFF;
      end else begin
         unique case (state_reg)
            S_DEAD: begin
               // Outputs are already low, so a retarget keeps the running count.
               target_next = request;
               if (cnt_zero) begin
                  state_next = target_next;
               end else begin
                  cnt_dec = 1'b1;
               end
            end
            default: begin
               if (request != state_reg) begin
                  state_next  = S_DEAD;
                  target_next = request;
                  cnt_load    = 1'b1;
               end
            end
         endcase
      end
   end

   // Pin values are computed from the next state so a command change shows up one clk later.
   always_comb begin
      in1_next = 1'b0;
      in2_next = 1'b0;
      dir_next = dir_reg;
      case (state_next)
         S_FWD: begin
            in1_next = bus.pwm_in;
            dir_next = 1'b0;
         end
         S_REV: begin
            in2_next = bus.pwm_in;
            dir_next = 1'b1;
         end
         S_BRAKE: begin
            in1_next = 1'b1;
            in2_next = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         in1_reg  <= 1'b0;
         in2_reg  <= 1'b0;
         busy_reg <= 1'b0;
         dir_reg  <= 1'b0;
      end else begin
         in1_reg  <= in1_next;
         in2_reg  <= in2_next;
         busy_reg <= (state_next == S_DEAD);
         dir_reg  <= dir_next;
      end
   end

   assign bus.bridge_in1 = in1_reg;
   assign bus.bridge_in2 = in2_reg;
   assign bus.dead_busy  = busy_reg;
   assign bus.dir_active = dir_reg;

endmodule

// File: tb/tb_h_bridge_drive.sv
// Self-checking bench for h_bridge_drive: directed dead-time scenarios plus random commands
// against a gap-counting reference model, with pin-level safety invariants.
module tb_h_bridge_drive;
   localparam int DTW = 8;
   localparam int OFF = 0, FWD = 1, REV = 2, BRK = 3;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   h_bridge_drive_if #(.DT_WIDTH(DTW)) bus ();

   h_bridge_drive #(.DT_WIDTH(DTW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // Reference model: what the bridge is applying, and how many gap cycles remain (-1 = none).
   int m_cur;
   int m_gap;
   bit m_dir, m_in1, m_in2;
   bit rand_pwm;
   int last_kind;
   bit zero_seen;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_cur = OFF; m_gap = -1; m_dir = 1'b0; m_in1 = 1'b0; m_in2 = 1'b0;
      last_kind = 0; zero_seen = 1'b1;
   endtask

   task automatic model_clock();
      int req;
      if (bus.mode == 2'b01)      req = bus.dir_cmd ? REV : FWD;
      else if (bus.mode == 2'b10) req = BRK;
      else                        req = OFF;
      if (req == OFF) begin
         m_cur = OFF; m_gap = -1;
      end else if (m_gap >= 0) begin
         if (m_gap == 0) begin m_cur = req; m_gap = -1; end
         else m_gap--;
      end else if (req != m_cur) begin
         m_gap = int'(bus.dead_time);
      end
      m_in1 = (m_gap < 0) && ((m_cur == FWD && bus.pwm_in) || m_cur == BRK);
      m_in2 = (m_gap < 0) && ((m_cur == REV && bus.pwm_in) || m_cur == BRK);
      if (m_gap < 0 && m_cur == FWD) m_dir = 1'b0;
      if (m_gap < 0 && m_cur == REV) m_dir = 1'b1;
   endtask

   task automatic step();
      int kind;
      @(posedge clk);
      if (!reset) model_reset();
      else        model_clock();
      #1;
      check("in1",  32'(bus.bridge_in1), 32'(m_in1));
      check("in2",  32'(bus.bridge_in2), 32'(m_in2));
      check("busy", 32'(bus.dead_busy),  32'(m_gap >= 0));
      check("dir",  32'(bus.dir_active), 32'(m_dir));
      check("overlap", 32'(bus.bridge_in1 & bus.bridge_in2 & !(m_gap < 0 && m_cur == BRK)), 32'd0);
      kind = {30'd0, bus.bridge_in1, bus.bridge_in2};
      if (kind == 0) begin
         zero_seen = 1'b1;
      end else begin
         if (last_kind != 0 && kind != last_kind) check("gap", 32'(zero_seen), 32'd1);
         last_kind = kind;
         zero_seen = 1'b0;
      end
      if (rand_pwm) bus.pwm_in = 1'($urandom_range(0, 1));
   endtask

   task automatic set_cmd(input logic [1:0] mode, input logic dir, input int dt);
      bus.mode = mode; bus.dir_cmd = dir; bus.dead_time = DTW'(dt);
   endtask

   // Applies the already-set command and counts dead_busy cycles, optionally changing command mid-gap.
   task automatic run_dead(input int flip_at, input logic [1:0] fmode, input logic fdir, output int cnt);
      step();
      cnt = 0;
      while (bus.dead_busy && cnt < 64) begin
         cnt++;
         if (cnt == flip_at) begin bus.mode = fmode; bus.dir_cmd = fdir; end
         step();
      end
   endtask

   task automatic async_reset_check(input string tag);
      #2 reset = 1'b0;
      #1;
      check({tag, "_in1"},  32'(bus.bridge_in1), 32'd0);
      check({tag, "_in2"},  32'(bus.bridge_in2), 32'd0);
      check({tag, "_busy"}, 32'(bus.dead_busy),  32'd0);
      check({tag, "_dir"},  32'(bus.dir_active), 32'd0);
      model_reset();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int cnt;
      rand_pwm = 1'b1;
      bus.pwm_in = 1'b0;
      set_cmd(2'b00, 1'b0, 0);
      model_reset();
      #2 reset = 1'b0;
      #1;
      check("rst_in1",  32'(bus.bridge_in1), 32'd0);
      check("rst_busy", 32'(bus.dead_busy),  32'd0);
      step(); step();
      reset = 1'b1;
      step();

      // Reset while driving forward with pwm high: pins drop without a clock edge.
      rand_pwm = 1'b0; bus.pwm_in = 1'b1;
      set_cmd(2'b01, 1'b0, 0);
      repeat (4) step();
      check("t1_pre_in1", 32'(bus.bridge_in1), 32'd1);
      async_reset_check("t1");
      bus.mode = 2'b00;
      step();
      reset = 1'b1;
      step();

      // OFF -> FWD with dead_time 5: six gap cycles, then pwm tracked one clk late.
      rand_pwm = 1'b1;
      set_cmd(2'b01, 1'b0, 5);
      run_dead(0, 2'b00, 1'b0, cnt);
      check("t2_dead_len", 32'(cnt), 32'd6);
      rand_pwm = 1'b0;
      bus.pwm_in = 1'b1; step();
      check("t2_track_hi", 32'(bus.bridge_in1), 32'd1);
      bus.pwm_in = 1'b0; step();
      check("t2_track_lo", 32'(bus.bridge_in1), 32'd0);
      rand_pwm = 1'b1;
      repeat (4) step();

      // FWD -> REV with dead_time 3.
      set_cmd(2'b01, 1'b1, 3);
      run_dead(0, 2'b00, 1'b0, cnt);
      check("t3_dead_len", 32'(cnt), 32'd4);
      repeat (3) step();
      check("t3_dir", 32'(bus.dir_active), 32'd1);
      check("t3_in1", 32'(bus.bridge_in1), 32'd0);

      // REV -> BRAKE -> REV with zero dead time: single-cycle gaps.
      set_cmd(2'b10, 1'b1, 0);
      run_dead(0, 2'b00, 1'b0, cnt);
      check("t4_dead_brk", 32'(cnt), 32'd1);
      check("t4_brake", 32'({bus.bridge_in1, bus.bridge_in2}), 32'd3);
      step(); step();
      set_cmd(2'b01, 1'b1, 0);
      run_dead(0, 2'b00, 1'b0, cnt);
      check("t4_dead_rev", 32'(cnt), 32'd1);
      check("t4_rev_in1", 32'(bus.bridge_in1), 32'd0);

      // Retarget mid-gap keeps the count; OFF mid-gap exits at once.
      set_cmd(2'b00, 1'b0, 0); step(); step();
      set_cmd(2'b01, 1'b0, 10);
      run_dead(4, 2'b01, 1'b1, cnt);
      check("t5_retarget_len", 32'(cnt), 32'd11);
      check("t5_dir", 32'(bus.dir_active), 32'd1);
      set_cmd(2'b00, 1'b0, 0); step(); step();
      set_cmd(2'b01, 1'b0, 10);
      run_dead(4, 2'b00, 1'b0, cnt);
      check("t5_off_len", 32'(cnt), 32'd4);
      check("t5_off_pins", 32'({bus.bridge_in1, bus.bridge_in2}), 32'd0);

      // Random command traffic with occasional asynchronous resets.
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 7) == 0) begin
            bus.mode      = 2'($urandom_range(0, 3));
            bus.dir_cmd   = 1'($urandom_range(0, 1));
            bus.dead_time = DTW'($urandom_range(0, 7));
         end
         if ($urandom_range(0, 99) == 0) async_reset_check("rnd_rst");
         else reset = 1'b1;
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
